// File: rtl/picorv32_sram_pkg.sv
// -----------------------------------------------------------------------------
// picorv32_sram_pkg
// Shared definitions for the picorv32 -> single-port SRAM bridge.
//   state_e    : bridge FSM states (IDLE, ISSUE, WAIT, RESP)
//   WAIT_CNT_W : width of the wait-state counter (supports 0..15 wait states)
// -----------------------------------------------------------------------------
package picorv32_sram_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/picorv32_sram_bridge.sv
// -----------------------------------------------------------------------------
// picorv32_sram_bridge
// Adapts the picorv32 native memory interface to a single-port synchronous
// SRAM (read data appears one clock after the address is sampled). One
// request is handled at a time: the request is latched in IDLE, driven to the
// SRAM for exactly one cycle (ISSUE), optionally stretched by WAIT_STATES idle
// cycles (WAIT), and answered with a one-cycle mem_ready pulse (RESP).
//
// Parameters:
//   ADDR_W      : SRAM word-address width (must be < 30)
//   WAIT_STATES : extra idle cycles between SRAM access and response (0..15)
//
// Ports:
//   clock, resetn          : clock (rising edge), async active-low reset
//   mem_valid/instr/addr/
//   wdata/wstrb            : picorv32 request (wstrb == 0 means read)
//   mem_ready, mem_rdata   : one-cycle completion pulse and read data
//   sram_address/byteena/
//   data/wren, sram_q      : SRAM port (registered outputs)
//   err                    : sticky out-of-range flag
//
// Build option:
//   SRAM_BRIDGE_RANGE_CHECK_EN : when defined, addresses beyond the SRAM are
//   blocked (no write, zero read data) and latch err until reset. When not
//   defined, upper address bits are ignored (aliasing) and err stays 0.
// -----------------------------------------------------------------------------
module picorv32_sram_bridge
  import picorv32_sram_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic [3:0]        sram_byteena,
  output logic [31:0]       sram_data,
  output logic              sram_wren,
  input  logic [31:0]       sram_q,
  output logic              err
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0]     sram_address_q, sram_address_d;
  logic [3:0]            sram_byteena_q, sram_byteena_d;
  logic [31:0]           sram_data_q, sram_data_d;
  logic                  sram_wren_q, sram_wren_d;
  // Response returns zero data: set for writes and blocked out-of-range reads.
  logic                  zero_rdata_q, zero_rdata_d;
  logic                  err_q, err_d;

  logic                  req_write;
  logic                  req_oor;

  // Fetch flag and byte-offset bits carry no meaning for a word-wide SRAM.
  logic unused_bits;
  assign unused_bits = &{1'b0, mem_instr, mem_addr[1:0]};

`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
  assign req_oor = |mem_addr[31:ADDR_W+2];
`else
  // Upper bits dropped: accesses alias modulo the SRAM size.
  assign req_oor = 1'b0;
  logic unused_hi;
  assign unused_hi = |mem_addr[31:ADDR_W+2];
`endif

  assign req_write = |mem_wstrb;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_ready_d    = mem_ready_q;
    mem_rdata_d    = mem_rdata_q;
    sram_address_d = sram_address_q;
    sram_byteena_d = sram_byteena_q;
    sram_data_d    = sram_data_q;
    sram_wren_d    = sram_wren_q;
    zero_rdata_d   = zero_rdata_q;
    err_d          = err_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          sram_address_d = mem_addr[ADDR_W+1:2];
          sram_data_d    = mem_wdata;
          if (req_oor) begin
            // Blocked access: the SRAM sees a request with no lanes enabled.
            sram_byteena_d = 4'h0;
            sram_wren_d    = 1'b0;
          end else begin
            sram_byteena_d = req_write ? mem_wstrb : 4'hF;
            sram_wren_d    = req_write;
          end
          zero_rdata_d = req_write | req_oor;
          err_d        = err_q | req_oor;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // SRAM has captured the access on this edge; drop the strobes but
        // keep the address so sram_q keeps reflecting the addressed word.
        sram_wren_d    = 1'b0;
        sram_byteena_d = 4'h0;
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q <= WAIT_CNT_W'(1)) begin
          wait_cnt_d = '0;
          state_d    = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end

      ST_RESP: begin
        // RESP spans two cycles: the first covers the SRAM read latency and
        // ends by registering the response, the second is the mem_ready cycle.
        if (!mem_ready_q) begin
          mem_ready_d = 1'b1;
          mem_rdata_d = zero_rdata_q ? 32'h0 : sram_q;
        end else begin
          mem_ready_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      mem_ready_q    <= 1'b0;
      mem_rdata_q    <= 32'h0;
      sram_address_q <= '0;
      sram_byteena_q <= 4'h0;
      sram_data_q    <= 32'h0;
      sram_wren_q    <= 1'b0;
      zero_rdata_q   <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_ready_q    <= mem_ready_d;
      mem_rdata_q    <= mem_rdata_d;
      sram_address_q <= sram_address_d;
      sram_byteena_q <= sram_byteena_d;
      sram_data_q    <= sram_data_d;
      sram_wren_q    <= sram_wren_d;
      zero_rdata_q   <= zero_rdata_d;
      err_q          <= err_d;
    end
  end

  assign mem_ready    = mem_ready_q;
  assign mem_rdata    = mem_rdata_q;
  assign sram_address = sram_address_q;
  assign sram_byteena = sram_byteena_q;
  assign sram_data    = sram_data_q;
  assign sram_wren    = sram_wren_q;
  assign err          = err_q;

endmodule
